// File: rtl/ifb_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package ifb_pkg;
  localparam int IFB_INST_WIDTH = 32;
  localparam int IFB_ADDR_WIDTH = 32;

  localparam logic [IFB_INST_WIDTH-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [IFB_ADDR_WIDTH-1:0] addr;
    logic [IFB_INST_WIDTH-1:0] inst;
  } ifb_entry_t;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction
endpackage

// File: rtl/ifb_fifo.sv
// DEPTH-entry synchronous FIFO of address/instruction pairs with clear.
module ifb_fifo import ifb_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  ifb_entry_t               i_push_data,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH):0]   o_count,
  output ifb_entry_t               o_head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ifb_entry_t    r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign w_do_pop  = i_pop & (r_count != '0);
  assign w_do_push = i_push & ((r_count != CW'(DEPTH)) | w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer between PC and decode: credit-limited reads, FIFO of responses.
// Optional IFB_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module inst_fetch_buf import ifb_pkg::*; #(
  parameter int INST_WIDTH = IFB_INST_WIDTH,
  parameter int ADDR_WIDTH = IFB_ADDR_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [INST_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_addr,
  input  logic                  flush,
  output logic                  misalign_err
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_inflight_addr;
  logic                  r_misalign;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_credits;
  ifb_entry_t    w_head;
  ifb_entry_t    w_push_entry;
  logic          w_aligned;
  logic          w_accept;
  logic          w_nonempty;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;

  // Credits count buffered plus in-flight entries, so a push can never overflow.
  assign w_credits = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign req_ready = rst & ~flush & (w_credits < (CW+1)'(DEPTH));

  assign w_aligned = is_aligned(req_addr[1:0]);
  assign w_accept  = req_valid & req_ready;
  assign mem_rd_en = w_accept & w_aligned;
  assign mem_addr  = req_addr;

  assign w_nonempty = (w_count != '0);
`ifdef IFB_BYPASS_EN
  assign w_bypass = rst & ~flush & r_inflight & ~w_nonempty;
`else
  assign w_bypass = 1'b0;
`endif

  assign out_valid = rst & (w_nonempty | w_bypass);
  assign w_pop     = out_valid & out_ready & ~flush & w_nonempty;
  assign w_push    = r_inflight & ~flush & ~(w_bypass & out_ready);

  assign w_push_entry.addr = r_inflight_addr;
  assign w_push_entry.inst = mem_rdata;

  always_comb begin
    out_inst = INST_WIDTH'(NOP_INST);
    out_addr = '0;
    if (w_bypass) begin
      out_inst = mem_rdata;
      out_addr = r_inflight_addr;
    end else if (out_valid) begin
      out_inst = w_head.inst;
      out_addr = w_head.addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_inflight <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_inflight <= mem_rd_en;
      if (w_accept && !w_aligned) r_misalign <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_rd_en) r_inflight_addr <= req_addr;
  end

  assign misalign_err = r_misalign;

  ifb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (flush),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head      (w_head)
  );
endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf with a one-cycle-latency memory model.
module tb_inst_fetch_buf;
`ifdef IFB_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        flush;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  inst_fetch_buf #(.INST_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_addr     (out_addr),
    .flush        (flush),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Data appears exactly one cycle after the strobe; otherwise garbage.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= inst_of(mem_addr);
    else           mem_rdata <= 32'hBAD0_BAD0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] a);
    chk({tag, "_valid"}, 64'(out_valid), 64'(v));
    if (v) begin
      chk({tag, "_addr"}, 64'(out_addr), 64'(a));
      chk({tag, "_inst"}, 64'(out_inst), 64'(inst_of(a)));
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int idx;
    rst = 1'b0; req_valid = 1'b1; req_addr = 32'h10; out_ready = 1'b0; flush = 1'b0;

    // Reset behaviour
    tick; tick;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_misalign", 64'(misalign_err), 64'd0);
    rst = 1'b1; req_valid = 1'b0;
    tick;

    // Streaming 0,4,8,12 with decode always ready
    req_valid = 1'b1; req_addr = 32'h0; out_ready = 1'b1; #1;
    chk("s_ready", 64'(req_ready), 64'd1);
    chk("s_rd_en", 64'(mem_rd_en), 64'd1);
    chk("s_maddr", 64'(mem_addr), 64'd0);
    chk("s_c0_valid", 64'(out_valid), 64'd0);
    for (int k = 1; k <= 6; k++) begin
      tick;
      if (k <= 3) req_addr = 32'(4 * k);
      else        req_valid = 1'b0;
      #1;
      idx = k - 2 + BYP;
      chk_out($sformatf("s_c%0d", k), (idx >= 0 && idx <= 3), 32'(4 * idx));
    end

    // Back-pressure: exactly DEPTH accepts
    tick;
    out_ready = 1'b0; req_valid = 1'b1; acc = 0;
    for (int k = 0; k < 8; k++) begin
      req_addr = 32'h100 + 32'(4 * acc);
      #1;
      if (req_ready) acc++;
      tick;
    end
    req_addr = 32'h100 + 32'(4 * acc); #1;
    chk("bp_accepts", 64'(acc), 64'd4);
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    tick;
    out_ready = 1'b1; #1;
    chk_out("bp_pop", 1'b1, 32'h100);
    chk("bp_ready_same", 64'(req_ready), 64'd0);
    tick;
    out_ready = 1'b0; #1;
    chk("bp_ready_next", 64'(req_ready), 64'd1);
    chk("bp_rd_en", 64'(mem_rd_en), 64'd1);
    chk("bp_maddr", 64'(mem_addr), 64'h110);

    // Pop while a response is in flight; order preserved
    tick;
    req_valid = 1'b0; out_ready = 1'b1; #1;
    chk_out("pp_0", 1'b1, 32'h104);
    chk("pp_ready0", 64'(req_ready), 64'd0);
    tick;
    chk("pp_ready1", 64'(req_ready), 64'd1);
    chk_out("pp_1", 1'b1, 32'h108);
    tick; chk_out("pp_2", 1'b1, 32'h10C);
    tick; chk_out("pp_3", 1'b1, 32'h110);
    tick; chk_out("pp_4", 1'b0, 32'h0);

    // Flush with 3 buffered and 1 in flight
    out_ready = 1'b0; req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_addr = 32'h200 + 32'(4 * k); #1;
      chk($sformatf("fl_acc%0d", k), 64'(req_ready), 64'd1);
      tick;
    end
    req_valid = 1'b0; flush = 1'b1; out_ready = 1'b1; #1;
    chk("fl_ready", 64'(req_ready), 64'd0);
    chk("fl_valid_in_flush", 64'(out_valid), 64'd1);
    tick;
    flush = 1'b0; out_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h40; #1;
    chk("fl_after_valid", 64'(out_valid), 64'd0);
    chk("fl_after_ready", 64'(req_ready), 64'd1);
    tick;
    req_valid = 1'b0; out_ready = 1'b1; #1;
    chk_out("fl_o0", (BYP == 1), 32'h40);
    tick; chk_out("fl_o1", (BYP == 0), 32'h40);
    tick; chk_out("fl_o2", 1'b0, 32'h0);

    // Misaligned request
    req_valid = 1'b1; req_addr = 32'h6; #1;
    chk("ma_ready", 64'(req_ready), 64'd1);
    chk("ma_rd_en", 64'(mem_rd_en), 64'd0);
    chk("ma_err0", 64'(misalign_err), 64'd0);
    tick;
    req_valid = 1'b0; #1;
    chk("ma_err1", 64'(misalign_err), 64'd1);
    chk_out("ma_o1", 1'b0, 32'h0);
    tick;
    chk("ma_err2", 64'(misalign_err), 64'd1);
    chk_out("ma_o2", 1'b0, 32'h0);
    flush = 1'b1; #1;
    chk("ma_err_flushcyc", 64'(misalign_err), 64'd1);
    tick;
    flush = 1'b0; #1;
    chk("ma_err_cleared", 64'(misalign_err), 64'd0);

    // Reset mid-stream
    out_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h300;
    tick; req_addr = 32'h304;
    tick; req_addr = 32'h301;
    tick; req_valid = 1'b0; #1;
    chk("mr_err_set", 64'(misalign_err), 64'd1);
    chk_out("mr_buffered", 1'b1, 32'h300);
    tick;
    rst = 1'b0; req_valid = 1'b1; req_addr = 32'h400; #1;
    chk("mr_ready_low", 64'(req_ready), 64'd0);
    chk("mr_rd_en_low", 64'(mem_rd_en), 64'd0);
    tick;
    chk("mr_post_valid", 64'(out_valid), 64'd0);
    chk("mr_post_err", 64'(misalign_err), 64'd0);
    chk("mr_post_ready", 64'(req_ready), 64'd0);
    chk("mr_post_rd_en", 64'(mem_rd_en), 64'd0);
    tick;
    rst = 1'b1; req_valid = 1'b0; #1;
    chk("mr_rel_valid", 64'(out_valid), 64'd0);
    chk("mr_rel_ready", 64'(req_ready), 64'd1);
    tick;
    chk("mr_rel_valid2", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
